// File: rtl/logu_serial_ctrl_pkg.sv
// logu_pkg: shared opcode/state types and opcode legality helper for logu_serial_ctrl
package logu_pkg;
  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOT = 3'd3,
    OP_SHL = 3'd4
  } op_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'(OP_SHL);
  endfunction
endpackage

// File: rtl/logu_serial_ctrl_if.sv
// logu_serial_ctrl_if: request/response handshake bundle for logu_serial_ctrl
//   req_valid/req_ready/req_op/req_a/req_b : operation request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err   : result response channel
//   rsp_parity                             : present only with LOGU_CTRL_PARITY_EN
//   master = issuer side, slave = controller side
interface logu_serial_ctrl_if #(parameter int WIDTH = 8);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
`ifdef LOGU_CTRL_PARITY_EN
  logic             rsp_parity;
`endif
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
`ifdef LOGU_CTRL_PARITY_EN
    , input rsp_parity
`endif
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
`ifdef LOGU_CTRL_PARITY_EN
    , output rsp_parity
`endif
  );
endinterface

// File: rtl/logu_serial_ctrl_bit_shifter.sv
// logu_bit_shifter: serial-in result capture register, LSB first
//   clk, rst_n : clock, async active-low reset
//   i_clr      : clear the register (new operation)
//   i_shift    : shift i_bit in at the MSB end
//   o_data     : captured word
module logu_bit_shifter #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] r_data;
  // Shifting in at the MSB means the first captured bit ends up at bit 0 after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_data <= '0;
    else if (i_clr) r_data <= '0;
    else if (i_shift) r_data <= {i_bit, r_data[WIDTH-1:1]};
  assign o_data = r_data;
endmodule

// File: rtl/logu_serial_ctrl.sv
// logu_serial_ctrl: bit-serial initiator driving a 1-bit logic unit
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : request/response handshake channels
//   o_lu_a, o_lu_b    : operand bits to the logic unit
//   o_lu_opsel0..2    : latched opcode bits to the logic unit
//   i_lu_out          : combinational result bit from the logic unit
//   LOGU_CTRL_PARITY_EN adds bus.rsp_parity = ^rsp_data
module logu_serial_ctrl
  import logu_pkg::*;
#(parameter int WIDTH = 8) (
  input  logic               clk,
  input  logic               rst_n,
  logu_serial_ctrl_if.slave  bus,
  output logic               o_lu_a,
  output logic               o_lu_b,
  output logic               o_lu_opsel0,
  output logic               o_lu_opsel1,
  output logic               o_lu_opsel2,
  input  logic               i_lu_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e           r_state, w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_err;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_run, w_done;
  logic [WIDTH-1:0] w_a_eff, w_result, w_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_accept = (r_state == IDLE) && bus.req_valid;
    w_run = r_state == RUN;
    w_done = r_state == DONE;
    w_next = (r_state == IDLE) ? (bus.req_valid ? (is_legal_op(bus.req_op) ? RUN : DONE) : IDLE)
           : w_run ? ((r_cnt == LAST) ? DONE : RUN)
           : (bus.rsp_ready ? IDLE : DONE);
    // SHL is done here: the unit passes a through, so feed it a pre-shifted operand.
    w_a_eff = (r_op == 3'(OP_SHL)) ? {r_a[WIDTH-2:0], 1'b0} : r_a;
    w_data = (w_done && !r_err) ? w_result : '0;
    bus.req_ready = r_state == IDLE;
    bus.rsp_valid = w_done;
    bus.rsp_data = w_data;
    bus.rsp_err = w_done && r_err;
`ifdef LOGU_CTRL_PARITY_EN
    bus.rsp_parity = ^w_data;
`endif
    o_lu_a = w_run && w_a_eff[r_cnt];
    o_lu_b = w_run && r_b[r_cnt];
    o_lu_opsel0 = w_run && r_op[0];
    o_lu_opsel1 = w_run && r_op[1];
    o_lu_opsel2 = w_run && r_op[2];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op <= bus.req_op;
      r_a <= bus.req_a;
      r_b <= bus.req_b;
      r_err <= !is_legal_op(bus.req_op);
      r_cnt <= '0;
    end else if (w_run) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
  logu_bit_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_shift (w_run),
    .i_bit   (i_lu_out),
    .o_data  (w_result)
  );
endmodule

// File: tb/tb_logu_serial_ctrl.sv
// tb_logu_serial_ctrl: directed self-checking bench for logu_serial_ctrl with a combinational logic-unit model
module tb_logu_serial_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu_a, lu_b, lu_op0, lu_op1, lu_op2, lu_out;
  int n_checks = 0;
  int n_fail = 0;
  logu_serial_ctrl_if #(.WIDTH(8)) bus ();
  logu_serial_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_lu_a      (lu_a),
    .o_lu_b      (lu_b),
    .o_lu_opsel0 (lu_op0),
    .o_lu_opsel1 (lu_op1),
    .o_lu_opsel2 (lu_op2),
    .i_lu_out    (lu_out)
  );
  always #5 clk = ~clk;
  always_comb begin
    lu_out = 1'b0;
    case ({lu_op2, lu_op1, lu_op0})
      3'd0: lu_out = lu_a & lu_b;
      3'd1: lu_out = lu_a | lu_b;
      3'd2: lu_out = lu_a ^ lu_b;
      3'd3: lu_out = ~lu_a;
      3'd4: lu_out = lu_a;
      default: lu_out = 1'b0;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, ".lu"}, 32'({lu_a, lu_b, lu_op2, lu_op1, lu_op0}), 32'd0);
`ifdef LOGU_CTRL_PARITY_EN
    chk({tag, ".parity"}, 32'(bus.rsp_parity), 32'd0);
`endif
  endtask
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    step();
    bus.req_valid = 1'b0;
  endtask
  task automatic check_run(input string tag, input logic [2:0] op, input logic [7:0] exp_a, input logic [7:0] exp_b);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.opsel%0d", tag, i), 32'({lu_op2, lu_op1, lu_op0}), 32'(op));
      chk($sformatf("%s.lu_a%0d", tag, i), 32'(lu_a), 32'(exp_a[i]));
      chk($sformatf("%s.lu_b%0d", tag, i), 32'(lu_b), 32'(exp_b[i]));
      chk($sformatf("%s.req_ready%0d", tag, i), 32'(bus.req_ready), 32'd0);
      chk($sformatf("%s.early_valid%0d", tag, i), 32'(bus.rsp_valid), 32'd0);
      step();
    end
  endtask
  task automatic check_done(input string tag, input logic [7:0] exp, input logic err, input int hold);
    for (int i = 0; i <= hold; i++) begin
      chk($sformatf("%s.rsp_valid%0d", tag, i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("%s.rsp_data%0d", tag, i), 32'(bus.rsp_data), 32'(exp));
      chk($sformatf("%s.rsp_err%0d", tag, i), 32'(bus.rsp_err), 32'(err));
      chk($sformatf("%s.req_ready%0d", tag, i), 32'(bus.req_ready), 32'd0);
      chk($sformatf("%s.lu_idle%0d", tag, i), 32'({lu_a, lu_b, lu_op2, lu_op1, lu_op0}), 32'd0);
`ifdef LOGU_CTRL_PARITY_EN
      chk($sformatf("%s.parity%0d", tag, i), 32'(bus.rsp_parity), 32'(^exp));
`endif
      if (i < hold) step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(bus.req_ready), 32'd1);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    chk_idle("in_reset");
    rst_n = 1'b1;
    step();
    chk_idle("after_reset");
    send(3'd0, 8'hF0, 8'h3C);
    check_run("and", 3'd0, 8'hF0, 8'h3C);
    check_done("and", 8'h30, 1'b0, 0);
    send(3'd2, 8'hAA, 8'hFF);
    check_run("xor", 3'd2, 8'hAA, 8'hFF);
    check_done("xor", 8'h55, 1'b0, 0);
    send(3'd3, 8'h0F, 8'h00);
    check_run("not", 3'd3, 8'h0F, 8'h00);
    check_done("not", 8'hF0, 1'b0, 0);
    send(3'd4, 8'h81, 8'h00);
    check_run("shl", 3'd4, 8'h02, 8'h00);
    check_done("shl", 8'h02, 1'b0, 0);
    send(3'd6, 8'hFF, 8'hFF);
    check_done("illegal", 8'h00, 1'b1, 0);
    send(3'd0, 8'h0F, 8'hFF);
    check_run("bp_and", 3'd0, 8'h0F, 8'hFF);
    bus.req_valid = 1'b1;
    bus.req_op = 3'd1;
    bus.req_a = 8'h81;
    bus.req_b = 8'h18;
    check_done("bp_and", 8'h0F, 1'b0, 5);
    step();
    bus.req_valid = 1'b0;
    chk("bp_accept", 32'(bus.req_ready), 32'd0);
    check_run("or", 3'd1, 8'h81, 8'h18);
    check_done("or", 8'h99, 1'b0, 0);
    send(3'd0, 8'hF0, 8'h3C);
    step();
    step();
    step();
    chk("mid_run_bit3", 32'(lu_a), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_idle("abort");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("abort.no_rsp%0d", i), 32'(bus.rsp_valid), 32'd0);
      step();
    end
    chk_idle("abort_idle");
    send(3'd0, 8'hF0, 8'h3C);
    check_run("and2", 3'd0, 8'hF0, 8'h3C);
    check_done("and2", 8'h30, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
